// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin two-requester front end for a shared 4-bit ALU,
// holding registered operands for SETTLE edges before capturing a tagged response.
module alu_share_arbiter #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_c,
    input  logic [2:0] req0_mode,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_c,
    input  logic [2:0] req1_mode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_c,
    output logic [2:0] alu_mode,
    input  logic [3:0] alu_r,
    input  logic       alu_ovf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_r,
    output logic       rsp_ovf,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [3:0] LOAD = 4'(SETTLE - 1);

    state_t     r_state, w_next;
    logic [3:0] r_count;
    logic       r_last;
    logic       w_acc0, w_acc1;

    // A requester's ready looks only at the other side's valid, so the grant is round-robin without depending on its own valid.
    assign req0_ready = (r_state == IDLE) && (!req1_valid || r_last);
    assign req1_ready = (r_state == IDLE) && (!req0_valid || !r_last);
    assign w_acc0     = req0_valid && req0_ready;
    assign w_acc1     = req1_valid && req1_ready;
    assign rsp_valid  = r_state == RESP;
    assign busy       = r_state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_acc0 || w_acc1) ? EXEC : IDLE;
            EXEC:    w_next = (r_count == 4'd0) ? RESP : EXEC;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_c    <= 1'b0;
            alu_mode <= 3'd0;
            rsp_id   <= 1'b0;
            rsp_r    <= 4'd0;
            rsp_ovf  <= 1'b0;
            r_count  <= 4'd0;
            r_last   <= 1'b1;
        end else if (w_acc0 || w_acc1) begin
            alu_a    <= w_acc1 ? req1_a : req0_a;
            alu_b    <= w_acc1 ? req1_b : req0_b;
            alu_c    <= w_acc1 ? req1_c : req0_c;
            alu_mode <= w_acc1 ? req1_mode : req0_mode;
            rsp_id   <= w_acc1;
            r_last   <= w_acc1;
            r_count  <= LOAD;
        end else if (r_state == EXEC) begin
            if (r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end else begin
                rsp_r   <= alu_r;
                rsp_ovf <= alu_ovf;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: two instances (SETTLE=1 and SETTLE=3) checked every cycle
// against a transaction-level model, plus literal expectations on selected responses.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0[2], v1[2], r0[2], r1[2], c0[2], c1[2], rr[2];
    logic [3:0] a0[2], b0[2], a1[2], b1[2];
    logic [2:0] md0[2], md1[2];
    logic [3:0] oa[2], ob[2], ar[2], rres[2], fval[2];
    logic       oc[2], aov[2], rv[2], rid[2], rov[2], bz[2], fon[2], fov[2];
    logic [2:0] om[2];

    for (genvar g = 0; g < 2; g++) begin : gi
        logic [4:0] w_sum;
        assign w_sum = 5'(oa[g]) + 5'(ob[g]) + 5'(oc[g]);
        assign ar[g]  = fon[g] ? fval[g] : w_sum[3:0];
        assign aov[g] = fon[g] ? fov[g] : w_sum[4];
        alu_share_arbiter #(.SETTLE(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0[g]), .req0_ready(r0[g]), .req0_a(a0[g]), .req0_b(b0[g]),
            .req0_c(c0[g]), .req0_mode(md0[g]),
            .req1_valid(v1[g]), .req1_ready(r1[g]), .req1_a(a1[g]), .req1_b(b1[g]),
            .req1_c(c1[g]), .req1_mode(md1[g]),
            .alu_a(oa[g]), .alu_b(ob[g]), .alu_c(oc[g]), .alu_mode(om[g]),
            .alu_r(ar[g]), .alu_ovf(aov[g]),
            .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_id(rid[g]), .rsp_r(rres[g]),
            .rsp_ovf(rov[g]), .busy(bz[g])
        );
    end

    function automatic int st(int k);
        return k == 0 ? 1 : 3;
    endfunction
    function automatic logic [3:0] add_r(logic [3:0] a, logic [3:0] b, logic c);
        return 4'((int'(a) + int'(b) + int'(c)) % 16);
    endfunction
    function automatic logic add_c(logic [3:0] a, logic [3:0] b, logic c);
        return (int'(a) + int'(b) + int'(c)) > 15;
    endfunction

    // Model: an operation is in flight from accept until its response is taken; the result is whatever the ALU shows SETTLE edges after accept.
    logic       m_busy[2], m_rsp[2], m_last[2], m_id[2], m_c[2], m_ovf[2];
    logic [3:0] m_a[2], m_b[2], m_r[2];
    logic [2:0] m_md[2];
    int         m_since[2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0; m_rsp[k] <= 1'b0; m_last[k] <= 1'b1; m_id[k] <= 1'b0;
                m_a[k] <= 4'd0; m_b[k] <= 4'd0; m_c[k] <= 1'b0; m_md[k] <= 3'd0;
                m_r[k] <= 4'd0; m_ovf[k] <= 1'b0; m_since[k] <= 0;
            end else if (!m_busy[k]) begin
                if (v0[k] && (!v1[k] || m_last[k])) begin
                    m_busy[k] <= 1'b1; m_since[k] <= 0; m_id[k] <= 1'b0; m_last[k] <= 1'b0;
                    m_a[k] <= a0[k]; m_b[k] <= b0[k]; m_c[k] <= c0[k]; m_md[k] <= md0[k];
                end else if (v1[k]) begin
                    m_busy[k] <= 1'b1; m_since[k] <= 0; m_id[k] <= 1'b1; m_last[k] <= 1'b1;
                    m_a[k] <= a1[k]; m_b[k] <= b1[k]; m_c[k] <= c1[k]; m_md[k] <= md1[k];
                end
            end else if (!m_rsp[k]) begin
                if (m_since[k] + 1 == st(k)) begin
                    m_rsp[k] <= 1'b1;
                    m_r[k]   <= fon[k] ? fval[k] : add_r(m_a[k], m_b[k], m_c[k]);
                    m_ovf[k] <= fon[k] ? fov[k] : add_c(m_a[k], m_b[k], m_c[k]);
                end else begin
                    m_since[k] <= m_since[k] + 1;
                end
            end else if (rr[k]) begin
                m_busy[k] <= 1'b0;
                m_rsp[k]  <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    logic       pin_id[2][8], pin_ov[2][8];
    logic [3:0] pin_r[2][8];
    int         pin_lat[2][8], pin_gap[2][8];
    int         pin_wr[2] = '{0, 0};
    int         pin_rd[2] = '{0, 0};
    int         acc_cyc[2] = '{0, 0};
    int         last_rise[2] = '{0, 0};
    logic       prv[2] = '{1'b0, 1'b0};
    int         checks = 0, errs = 0, p;

    task automatic chk(string nm, int k, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d got %h want %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk or posedge rst);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("req0_ready", k, 4'(r0[k]), 4'(!m_busy[k] && (!v1[k] || m_last[k])));
            chk("req1_ready", k, 4'(r1[k]), 4'(!m_busy[k] && (!v0[k] || !m_last[k])));
            chk("alu_a", k, oa[k], m_a[k]);
            chk("alu_b", k, ob[k], m_b[k]);
            chk("alu_c", k, 4'(oc[k]), 4'(m_c[k]));
            chk("alu_mode", k, 4'(om[k]), 4'(m_md[k]));
            chk("rsp_valid", k, 4'(rv[k]), 4'(m_rsp[k]));
            chk("rsp_id", k, 4'(rid[k]), 4'(m_id[k]));
            chk("rsp_r", k, rres[k], m_r[k]);
            chk("rsp_ovf", k, 4'(rov[k]), 4'(m_ovf[k]));
            chk("busy", k, 4'(bz[k]), 4'(m_busy[k]));
            if (rv[k] && !prv[k] && pin_rd[k] < pin_wr[k]) begin
                p = pin_rd[k];
                chk("pin_id", k, 4'(rid[k]), 4'(pin_id[k][p]));
                chk("pin_r", k, rres[k], pin_r[k][p]);
                chk("pin_ovf", k, 4'(rov[k]), 4'(pin_ov[k][p]));
                chk("pin_model_r", k, m_r[k], pin_r[k][p]);
                if (pin_lat[k][p] > 0) chk("pin_latency", k, 4'(cyc - acc_cyc[k]), 4'(pin_lat[k][p]));
                if (pin_gap[k][p] > 0) chk("pin_period", k, 4'(cyc - last_rise[k]), 4'(pin_gap[k][p]));
                pin_rd[k] = pin_rd[k] + 1;
            end
            if (rv[k] && !prv[k]) last_rise[k] = cyc;
            prv[k] = rv[k];
            if ((v0[k] && r0[k]) || (v1[k] && r1[k])) acc_cyc[k] = cyc;
        end
    end

    task automatic pin(int k, logic id, logic [3:0] r, logic ov, int lat, int gap);
        pin_id[k][pin_wr[k]]  = id;
        pin_r[k][pin_wr[k]]   = r;
        pin_ov[k][pin_wr[k]]  = ov;
        pin_lat[k][pin_wr[k]] = lat;
        pin_gap[k][pin_wr[k]] = gap;
        pin_wr[k] = pin_wr[k] + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(int k, logic w, logic [3:0] a, logic [3:0] b, logic c, logic [2:0] m);
        if (w) begin a1[k] = a; b1[k] = b; c1[k] = c; md1[k] = m; v1[k] = 1'b1; end
        else   begin a0[k] = a; b0[k] = b; c0[k] = c; md0[k] = m; v0[k] = 1'b1; end
    endtask

    task automatic issue(int k, logic w, logic [3:0] a, logic [3:0] b, logic c, logic [2:0] m);
        logic ok, done;
        done = 1'b0;
        set_op(k, w, a, b, c, m);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #1 ok = w ? r1[k] : r0[k];
            @(posedge clk);
            done = ok;
        end
        if (!done) begin
            $display("FAIL accept_timeout inst%0d requester %0d", k, w);
            $fatal(1);
        end
        #2;
        if (w) v1[k] = 1'b0; else v0[k] = 1'b0;
    endtask

    task automatic wait_idle(int k);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1 done = !bz[k];
        end
        if (!done) begin
            $display("FAIL idle_timeout inst%0d", k);
            $fatal(1);
        end
        tick();
    endtask

    task automatic rand_cycle(int k);
        logic acc0, acc1;
        @(negedge clk);
        #1;
        acc0 = v0[k] && r0[k];
        acc1 = v1[k] && r1[k];
        tick();
        if (!v0[k] || acc0) begin
            v0[k] = ($urandom_range(0, 2) != 0);
            a0[k] = 4'($urandom); b0[k] = 4'($urandom); c0[k] = 1'($urandom); md0[k] = 3'($urandom);
        end
        if (!v1[k] || acc1) begin
            v1[k] = ($urandom_range(0, 2) != 0);
            a1[k] = 4'($urandom); b1[k] = 4'($urandom); c1[k] = 1'($urandom); md1[k] = 3'($urandom);
        end
        rr[k] = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            v0[k] = 0; v1[k] = 0; a0[k] = 0; b0[k] = 0; c0[k] = 0; md0[k] = 0;
            a1[k] = 0; b1[k] = 0; c1[k] = 0; md1[k] = 0; rr[k] = 1;
            fon[k] = 0; fval[k] = 0; fov[k] = 0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        pin(0, 1'b0, 4'b0000, 1'b1, 2, 0);
        issue(0, 1'b0, 4'b0101, 4'b1010, 1'b1, 3'b000);
        wait_idle(0);

        issue(0, 1'b1, 4'd3, 4'd4, 1'b0, 3'd2);
        #5 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        pin(0, 1'b0, 4'b1000, 1'b0, 2, 0);
        pin(0, 1'b1, 4'b1111, 1'b0, 2, 3);
        pin(0, 1'b0, 4'b1000, 1'b0, 2, 3);
        pin(0, 1'b1, 4'b1111, 1'b0, 2, 3);
        set_op(0, 1'b0, 4'b0011, 4'b0101, 1'b0, 3'd0);
        set_op(0, 1'b1, 4'b1100, 4'b0011, 1'b0, 3'd0);
        repeat (14) tick();
        v0[0] = 0; v1[0] = 0;
        wait_idle(0);

        rr[0] = 1'b0;
        pin(0, 1'b0, 4'b0000, 1'b1, 2, 0);
        issue(0, 1'b0, 4'b1001, 4'b0111, 1'b0, 3'd1);
        tick();
        set_op(0, 1'b1, 4'd2, 4'd2, 1'b1, 3'd4);
        fon[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fval[0] = ~fval[0] ^ 4'(i);
            fov[0]  = ~fov[0];
            tick();
        end
        fon[0] = 1'b0;
        rr[0] = 1'b1;
        issue(0, 1'b1, 4'd2, 4'd2, 1'b1, 3'd4);
        wait_idle(0);

        fon[1] = 1'b1; fval[1] = 4'd0; fov[1] = 1'b0;
        pin(1, 1'b0, 4'b0111, 1'b0, 4, 0);
        issue(1, 1'b0, 4'd1, 4'd2, 1'b0, 3'd3);
        tick();
        tick();
        fval[1] = 4'b0111;
        tick();
        fval[1] = 4'b0000;
        wait_idle(1);
        fon[1] = 1'b0;

        issue(1, 1'b1, 4'd3, 4'd3, 1'b0, 3'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        pin(1, 1'b0, 4'b1000, 1'b0, 4, 0);
        pin(1, 1'b1, 4'b1111, 1'b0, 4, 5);
        set_op(1, 1'b0, 4'b0011, 4'b0101, 1'b0, 3'd0);
        set_op(1, 1'b1, 4'b1100, 4'b0011, 1'b0, 3'd0);
        repeat (12) tick();
        v0[1] = 0; v1[1] = 0;
        wait_idle(1);

        for (int k = 0; k < 2; k++) begin
            repeat (300) rand_cycle(k);
            v0[k] = 0; v1[k] = 0; rr[k] = 1;
            wait_idle(k);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
